ps2_note_decoder: RTL and testbench



---
 rtl/ps2_note_pkg.sv | 56 +++++
 rtl/ps2_frame_rx.sv | 105 ++++++++++
 rtl/ps2_note_decoder.sv | 77 +++++++
 tb/tb_ps2_note_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_note_pkg.sv
// Shared types and constants for the PS/2 note decoder: frame states, scan
// code prefixes and the set-2 key map onto the 25-note chromatic range.
package ps2_note_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [4:0] NOTE_NONE = 5'd31;

  typedef struct packed {
    logic       hit;
    logic [4:0] note;
  } key_map_t;

  function automatic key_map_t key_map(input logic [7:0] code);
    key_map_t km;
    km.hit  = 1'b1;
    km.note = NOTE_NONE;
    case (code)
      8'h1A: km.note = 5'd0;
      8'h1B: km.note = 5'd1;
      8'h22: km.note = 5'd2;
      8'h23: km.note = 5'd3;
      8'h21: km.note = 5'd4;
      8'h2A: km.note = 5'd5;
      8'h34: km.note = 5'd6;
      8'h32: km.note = 5'd7;
      8'h33: km.note = 5'd8;
      8'h31: km.note = 5'd9;
      8'h3B: km.note = 5'd10;
      8'h3A: km.note = 5'd11;
      8'h15: km.note = 5'd12;
      8'h1E: km.note = 5'd13;
      8'h1D: km.note = 5'd14;
      8'h26: km.note = 5'd15;
      8'h24: km.note = 5'd16;
      8'h2D: km.note = 5'd17;
      8'h2E: km.note = 5'd18;
      8'h2C: km.note = 5'd19;
      8'h36: km.note = 5'd20;
      8'h35: km.note = 5'd21;
      8'h3D: km.note = 5'd22;
      8'h3C: km.note = 5'd23;
      8'h43: km.note = 5'd24;
      default: km.hit = 1'b0;
    endcase
    return km;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises the raw lines, samples on
// PS/2 clock falling edges, checks odd parity and stop bit, aborts stalled frames.
module ps2_frame_rx
  import ps2_note_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic          ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic          ps2_data_p0, ps2_data_p1;
  logic          fall;
  logic          bit_in;
  logic          timeout;
  frame_state_e  state;
  logic [2:0]    bit_cnt;
  logic          par_acc;
  logic          par_ok;
  logic [TW-1:0] tmo_cnt;

  // Synchroniser stages; idle-high lines reset to 1 so no false edge appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign fall    = ps2_clk_p2 & ~ps2_clk_p1;
  assign bit_in  = ps2_data_p1;
  assign timeout = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST);

  // Frame FSM stage: byte_vld and frame_err are single-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      par_acc   <= 1'b0;
      par_ok    <= 1'b0;
      tmo_cnt   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 1'b1;

      if (timeout) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              par_acc <= 1'b0;
            end
          end
          DATA: begin
            par_acc <= par_acc ^ bit_in;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_ok <= par_acc ^ bit_in;
            state  <= STOP;
          end
          STOP: begin
            if (bit_in && par_ok) byte_vld  <= 1'b1;
            else                  frame_err <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Data shift register carries no reset; it is only read under byte_vld.
  always_ff @(posedge clk) begin
    if (fall && state == DATA) rx_byte <= {bit_in, rx_byte[7:1]};
  end

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 keyboard to note index: decodes set-2 make/break sequences into the
// last-pressed held note with key_on/key_off strobes.
module ps2_note_decoder
  import ps2_note_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] note,
  output logic       note_valid,
  output logic       key_on,
  output logic       key_off,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_vld;
  logic       ext_flag;
  logic       brk_flag;
  key_map_t   km;

  ps2_frame_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  assign km = key_map(rx_byte);

  // Decode stage: prefixes arm flags, any other byte consumes and clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note       <= NOTE_NONE;
      note_valid <= 1'b0;
      key_on     <= 1'b0;
      key_off    <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
    end else begin
      key_on  <= 1'b0;
      key_off <= 1'b0;
      if (byte_vld) begin
        if (rx_byte == SC_EXT) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == SC_BREAK) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (!ext_flag && km.hit) begin
            if (brk_flag) begin
              if (km.note == note) begin
                note       <= NOTE_NONE;
                note_valid <= 1'b0;
                key_off    <= 1'b1;
              end
            end else if (km.note != note) begin
              note       <= km.note;
              note_valid <= 1'b1;
              key_on     <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Scoreboard bench for ps2_note_decoder: a list-based key model predicts
// key_on/key_off/frame_err events; a monitor pops and compares them.
module tb_ps2_note_decoder;

  localparam int TMO  = 200;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] note;
  logic       note_valid, key_on, key_off, frame_err;

  ps2_note_decoder #(.TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .note       (note),
    .note_valid (note_valid),
    .key_on     (key_on),
    .key_off    (key_off),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 key_on, 1 key_off, 2 frame_err
    int note;
    int lat;    // clk edges from stop-bit falling edge, -1 = not checked
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  stop_cyc = 0;
  int  m_note = 31;
  bit  m_ext = 0, m_brk = 0;

  // Note index is the position of the scan code in this list.
  logic [7:0] key_codes [25] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34,
                                 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h15, 8'h1E,
                                 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36,
                                 8'h35, 8'h3D, 8'h3C, 8'h43};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int lookup(input logic [7:0] c);
    for (int i = 0; i < 25; i++) if (key_codes[i] == c) return i;
    return -1;
  endfunction

  task automatic push_ev(input int kind, input int n, input int lat);
    ev_t e;
    e.kind = kind; e.note = n; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = lookup(b);
      if (!m_ext && k >= 0) begin
        if (m_brk) begin
          if (k == m_note) begin m_note = 31; push_ev(1, 31, 4); end
        end else if (k != m_note) begin
          m_note = k; push_ev(0, k, 4);
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input logic b, input bit is_stop);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    if (bad_par || bad_stop) push_ev(2, m_note, 3);
    else model_byte(b);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit((~^b) ^ bad_par, 0);
    ps2_bit(~bad_stop, 1);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 0);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on any pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      check("note_valid_vs_note", note_valid, (note != 5'd31));
      if (key_on && key_off) check("on_off_exclusive", 1, 0);
      if (key_on || key_off || frame_err) begin
        int kind;
        ev_t e;
        kind = key_on ? 0 : (key_off ? 1 : 2);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse_kind", kind, -1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind, e.kind);
          check("event_note", note, e.note);
          if (e.lat >= 0) check("event_latency", cyc - stop_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    int r;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("reset_note", note, 31);
    check("reset_note_valid", note_valid, 0);
    check("reset_pulses", {key_on, key_off, frame_err}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed sequences from the test plan.
    send_frame(8'h1A);
    check("press_1A_note", note, 0);
    send_frame(8'h1A); send_frame(8'h1A); send_frame(8'h1A);
    send_frame(8'hF0); send_frame(8'h1A);
    check("break_1A_note", note, 31);
    send_frame(8'h1B); send_frame(8'h43);
    send_frame(8'hF0); send_frame(8'h1B);
    check("stale_break_note", note, 24);
    send_frame(8'hF0); send_frame(8'h43);
    check("break_43_note", note, 31);
    send_frame(8'h22, 1, 0);
    send_frame(8'h22, 0, 1);
    check("errors_keep_note", note, 31);
    send_frame(8'hE0); send_frame(8'h1A);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h1A);
    check("extended_ignored", note, 31);

    push_ev(2, m_note, -1);
    send_partial(8'h55, 4);
    repeat (TMO + 30) @(negedge clk);
    send_frame(8'h21);
    check("after_timeout_note", note, 4);

    // Randomised traffic against the list model.
    for (int n = 0; n < 70; n++) begin
      r = $urandom_range(0, 9);
      b = key_codes[$urandom_range(0, 24)];
      case (r)
        0, 1, 2, 3: send_frame(b);
        4, 5: begin
          if (m_note != 31 && r == 4) b = key_codes[m_note];
          send_frame(8'hF0); send_frame(b);
        end
        6: begin send_frame(8'hE0); send_frame(b); end
        7: begin
          b = 8'($urandom);
          if (b == 8'hE0 || b == 8'hF0) b = 8'h00;
          send_frame(b);
        end
        8: send_frame(8'($urandom), 1, 0);
        default: send_frame(8'($urandom), 0, 1);
      endcase
    end
    check("random_final_note", note, m_note);

    // Reset during a frame while a note is held.
    send_frame(8'h24);
    check("hold_16_note", note, 16);
    send_partial(8'h3C, 3);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midreset_note", note, 31);
    check("midreset_note_valid", note_valid, 0);
    check("midreset_pulses", {key_on, key_off, frame_err}, 0);
    check("midreset_pending_events", exp_q.size(), 0);
    m_note = 31; m_ext = 0; m_brk = 0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h2C);
    check("post_reset_note", note, 19);

    repeat (50) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("end_note", note, m_note);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
